// File: rtl/filter_load_ctrl.sv
// filter_load_ctrl: sequences an optional sweep-clear of the coefficient
// memory, streams NUM_TAPS coefficients into it, reads the whole kernel back
// in one access and holds it on coef_out until the consumer acknowledges.
module filter_load_ctrl #(
  parameter int unsigned NUM_TAPS = 9,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         cfg_clear,
  input  logic                         abort,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         mem_clr,
  output logic                         mem_we,
  output logic                         mem_re,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [NUM_TAPS*DATA_W-1:0]   mem_rdata,
  output logic [NUM_TAPS*DATA_W-1:0]   coef_out,
  output logic                         coef_valid,
  input  logic                         coef_ack,
  output logic                         busy,
  output logic                         load_done
);

  localparam int unsigned IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned COEF_W = NUM_TAPS * DATA_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_READ    = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

  logic             clr_c;
  logic             we_c;
  logic             re_c;

  // Control FSM: sequencing, tap index and the latched kernel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      coef_out   <= '0;
      coef_valid <= 1'b0;
      load_done  <= 1'b0;
    end else if (abort) begin
      // coef_out is left as is; coef_valid dropping is what retracts it.
      state      <= S_IDLE;
      idx        <= '0;
      coef_valid <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= cfg_clear ? S_CLEAR : S_LOAD;
          end
        end
        S_CLEAR: begin
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= S_LOAD;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        S_LOAD: begin
          // A gap in the stream simply stalls here with idx held.
          if (in_valid) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_READ;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          coef_out   <= COEF_W'(mem_rdata);
          coef_valid <= 1'b1;
          load_done  <= 1'b1;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (coef_ack) begin
            coef_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Memory strobes decoded from the state register; the write follows the
  // stream handshake in the same cycle, so at most one strobe is ever high.
  always_comb begin
    clr_c = (state == S_CLEAR);
    we_c  = (state == S_LOAD) && in_valid;
    re_c  = (state == S_READ);
  end

  // Port drive: handshake, status, address and write data.
  always_comb begin
    in_ready  = (state == S_LOAD);
    busy      = (state != S_IDLE);
    mem_clr   = clr_c;
    mem_we    = we_c;
    mem_re    = re_c;
    mem_addr  = (clr_c || we_c) ? ADDR_W'(idx) : '0;
    mem_wdata = we_c ? in_data : '0;
  end

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Scoreboard bench for filter_load_ctrl: directed loads push the expected
// memory strobes and kernels; a negedge monitor pops and compares them.
module tb_filter_load_ctrl;

  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned COEF_W   = NUM_TAPS * DATA_W;

  logic                clk;
  logic                reset;
  logic                start;
  logic                cfg_clear;
  logic                abort;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic                mem_clr;
  logic                mem_we;
  logic                mem_re;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [COEF_W-1:0]   mem_rdata;
  logic [COEF_W-1:0]   coef_out;
  logic                coef_valid;
  logic                coef_ack;
  logic                busy;
  logic                load_done;

  filter_load_ctrl #(
    .NUM_TAPS(NUM_TAPS),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_clear (cfg_clear),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_clr   (mem_clr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .coef_out  (coef_out),
    .coef_valid(coef_valid),
    .coef_ack  (coef_ack),
    .busy      (busy),
    .load_done (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural coefficient memory; tap 0 lands in the MSBs of mem_rdata.
  logic [DATA_W-1:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_clr) mem[mem_addr] <= '0;
    if (mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_re)
      for (int t = 0; t < NUM_TAPS; t++)
        mem_rdata[(NUM_TAPS-1-t)*DATA_W +: DATA_W] <= mem[t];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [COEF_W-1:0] coef;
    int                at;
  } kv_t;

  wr_t               wq[$];
  logic [ADDR_W-1:0] cq[$];
  kv_t               kq[$];
  int                rq = 0;

  logic              mon_en = 1'b0;
  logic              prev_valid = 1'b0;
  logic [COEF_W-1:0] prev_coef = '0;

  // Monitor: compares every strobe and kernel against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_onehot", 128'(int'(mem_clr) + int'(mem_we) + int'(mem_re) <= 1), 128'(1));
      if (mem_we) begin
        if (wq.size() == 0) flag("unexpected_write");
        else check("write_addr_data", {mem_addr, mem_wdata}, wq.pop_front());
      end
      if (mem_clr) begin
        if (cq.size() == 0) flag("unexpected_clear");
        else check("clear_addr", mem_addr, cq.pop_front());
      end
      if (mem_re) begin
        if (rq == 0) flag("unexpected_read");
        else rq--;
      end
      if (!mem_we && !mem_clr) check("addr_zero", mem_addr, 0);
      if (load_done) begin
        check("load_done_rise", {prev_valid, coef_valid}, 2'b01);
        if (kq.size() == 0) flag("unexpected_kernel");
        else begin
          kv_t k;
          k = kq.pop_front();
          check("kernel", coef_out, k.coef);
          check("valid_cycle", cyc, k.at);
        end
      end
      if (coef_valid && prev_valid) check("coef_stable", coef_out, prev_coef);
      prev_valid <= coef_valid;
      prev_coef  <= coef_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [COEF_W-1:0] bytes, input logic [8:0] gaps, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = bytes[(8-i)*8 +: 8];
      guard = 0;
      while (!in_ready && guard < 40) begin
        tick();
        guard++;
      end
      check("in_ready_wait", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic clr, input logic [COEF_W-1:0] bytes, input logic [8:0] gaps,
                         input logic [COEF_W-1:0] exp_coef, input int ack_delay, input logic ack_early);
    int s;
    int guard;
    s = cyc;
    if (clr) for (int i = 0; i < NUM_TAPS; i++) cq.push_back(ADDR_W'(i));
    for (int i = 0; i < NUM_TAPS; i++) wq.push_back({ADDR_W'(i), bytes[(8-i)*8 +: 8]});
    rq++;
    kq.push_back('{exp_coef, s + 1 + (clr ? 9 : 0) + 9 + $countones(gaps) + 2});
    start     = 1'b1;
    cfg_clear = clr;
    coef_ack  = ack_early;
    tick();
    start     = 1'b0;
    cfg_clear = 1'b0;
    send_bytes(bytes, gaps, NUM_TAPS);
    guard = 0;
    while (!coef_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("coef_valid_wait", coef_valid, 1'b1);
    for (int k = 0; k < ack_delay; k++) begin
      coef_ack = 1'b0;
      start    = (k % 2 == 0);
      tick();
      start = 1'b0;
      check("hold_no_restart", {busy, in_ready, coef_valid}, 3'b101);
    end
    coef_ack = 1'b1;
    tick();
    coef_ack = 1'b0;
    check("ack_release", {busy, in_ready, coef_valid}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_clear = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; coef_ack = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset_ctrl", {busy, in_ready, coef_valid, load_done, mem_clr, mem_we, mem_re}, 7'b0);
    check("reset_coef", coef_out, 0);
    check("reset_addr", mem_addr, 0);

    // Plain load, back-to-back stream.
    do_load(1'b0, 72'h010203040506070809, 9'b0, 72'h010203040506070809, 1, 1'b0);
    // Clear then load; ack held high the whole time is ignored until HOLD.
    do_load(1'b1, 72'h111213141516171819, 9'b0, 72'h111213141516171819, 0, 1'b1);
    // Stream with a gap before every byte after the first.
    do_load(1'b0, 72'hA55AFF00807F01FE3C, 9'b111111110, 72'hA55AFF00807F01FE3C, 1, 1'b0);

    // Abort after four accepted bytes, then reload from address 0.
    for (int i = 0; i < 4; i++) wq.push_back({ADDR_W'(i), 8'(8'h31 + i)});
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bytes(72'h313233343536373839, 9'b0, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_load_idle", {busy, in_ready, coef_valid}, 3'b000);
    do_load(1'b0, 72'h212223242526272829, 9'b0, 72'h212223242526272829, 1, 1'b0);

    // Abort in the third clear cycle.
    for (int i = 0; i < 3; i++) cq.push_back(ADDR_W'(i));
    start = 1'b1;
    cfg_clear = 1'b1;
    tick();
    start = 1'b0;
    cfg_clear = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_clear_idle", {busy, mem_clr}, 2'b00);

    // Long hold with start pulses that must be ignored.
    do_load(1'b0, 72'h919293949596979899, 9'b0, 72'h919293949596979899, 5, 1'b0);

    // Reset in LOAD with idx at 5.
    for (int i = 0; i < 5; i++) wq.push_back({ADDR_W'(i), 8'(8'h41 + i)});
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bytes(72'h414243444546474849, 9'b0, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_ctrl", {busy, in_ready, coef_valid, load_done, mem_clr, mem_we, mem_re}, 7'b0);
    check("reset_mid_coef", coef_out, 0);
    check("reset_mid_addr", mem_addr, 0);

    // Recovery after reset.
    do_load(1'b0, 72'h0F1E2D3C4B5A697887, 9'b0, 72'h0F1E2D3C4B5A697887, 1, 1'b0);

    repeat (3) tick();
    check("writes_drained", wq.size(), 0);
    check("clears_drained", cq.size(), 0);
    check("reads_drained", rq, 0);
    check("kernels_drained", kq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
